// File: rtl/pll_reset_sequencer.sv
// Qualifies the asynchronous PLL lock, then releases a stretched system reset and ready flag.
// Optional lock-loss event counter enabled by defining PLL_RESET_SEQ_LOSS_COUNT_EN.
//
// state      | meaning
// WAIT_LOCK  | reset asserted, waiting for synchronized lock
// STABILIZE  | lock seen, counting LOCK_STABLE_CYCLES consecutive locked cycles
// HOLD_RESET | lock qualified, holding reset for RESET_HOLD_CYCLES
// RUN        | reset released, sysReady high
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  ,
  parameter int LOSS_CNT_WIDTH     = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic isLocked,
  output logic sysReset,
  output logic sysReady,
  output logic lockLost
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [LOSS_CNT_WIDTH-1:0] lossCount
`endif
);

  localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                              LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    HOLD_RESET = 2'd2,
    RUN        = 2'd3
  } stateT;

  stateT              state;
  stateT              stateNext;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   countNext;
  logic [SYNC_STAGES-1:0] syncReg;
  logic               lockSync;
  logic               lossEvent;

  assign lockSync = syncReg[SYNC_STAGES-1];

  always_comb begin
    stateNext = state;
    countNext = count;
    lossEvent = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lockSync) stateNext = STABILIZE;
      end
      STABILIZE: begin
        if (!lockSync)                 stateNext = WAIT_LOCK;
        else if (count == STABLE_LAST) stateNext = HOLD_RESET;
        else                           countNext = count + 1'b1;
      end
      HOLD_RESET: begin
        // loss takes priority over the terminal count
        if (!lockSync) begin
          stateNext = WAIT_LOCK;
          lossEvent = 1'b1;
        end else if (count == HOLD_LAST) begin
          stateNext = RUN;
        end else begin
          countNext = count + 1'b1;
        end
      end
      RUN: begin
        if (!lockSync) begin
          stateNext = WAIT_LOCK;
          lossEvent = 1'b1;
        end
      end
      default: stateNext = WAIT_LOCK;
    endcase
    if (stateNext != state) countNext = '0;
  end

  // outputs decoded from next-state so they move on the same edge as the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      syncReg  <= '0;
      state    <= WAIT_LOCK;
      count    <= '0;
      sysReset <= 1'b1;
      sysReady <= 1'b0;
      lockLost <= 1'b0;
    end else begin
      syncReg  <= {syncReg[SYNC_STAGES-2:0], isLocked};
      state    <= stateNext;
      count    <= countNext;
      sysReset <= (stateNext != RUN);
      sysReady <= (stateNext == RUN);
      lockLost <= lossEvent;
    end
  end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      lossCount <= '0;
    end else if (lossEvent && (lossCount != LOSS_MAX)) begin
      lossCount <= lossCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus randomized lock traffic
// checked against a run-length reference model. Define PLL_RESET_SEQ_LOSS_COUNT_EN to cover lossCount.
module tb_pll_reset_sequencer;
  localparam int SS = 2;
  localparam int LS = 8;
  localparam int HC = 4;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic isLocked = 1'b0;
  logic sysReset, sysReady, lockLost;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [LW-1:0] lossCount;
`endif

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS),
    .LOCK_STABLE_CYCLES(LS),
    .RESET_HOLD_CYCLES(HC)
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    ,
    .LOSS_CNT_WIDTH(LW)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .isLocked(isLocked),
    .sysReset(sysReset),
    .sysReady(sysReady),
    .lockLost(lockLost)
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    ,
    .lossCount(lossCount)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference model: lock seen by the sequencer is isLocked delayed SS edges;
  // the sequencer is fully described by the length of the current run of locked samples.
  bit syncQ[$];
  int runLen;
  bit mReset = 1'b1;
  bit mReady = 1'b0;
  bit mLost = 1'b0;
  int mLoss = 0;

  task automatic tick();
    bit s;
    @(posedge clk);
    if (reset) begin
      syncQ = {};
      for (int i = 0; i < SS; i++) syncQ.push_back(1'b0);
      runLen = 0;
      mReset = 1'b1;
      mReady = 1'b0;
      mLost  = 1'b0;
      mLoss  = 0;
    end else begin
      s = syncQ.pop_front();
      syncQ.push_back(isLocked);
      mLost  = !s && (runLen > LS);
      runLen = s ? ((runLen < 1000000) ? runLen + 1 : runLen) : 0;
      mReady = (runLen > LS + HC);
      mReset = !mReady;
      if (mLost && (mLoss < (1 << LW) - 1)) mLoss++;
    end
    #1;
  endtask

  task automatic startLocked();
    reset = 1'b1;
    isLocked = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    isLocked = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    isLocked = 1'b1;
    repeat (3) tick();
    total++;
    if ({sysReset, sysReady, lockLost} !== 3'b100) begin
      bad++;
      $display("FAIL reset_values got=%b want=100", {sysReset, sysReady, lockLost});
    end
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    total++;
    if (lossCount !== '0) begin
      bad++;
      $display("FAIL reset_lossCount got=%0d want=0", lossCount);
    end
`endif
  endtask

  task automatic test_power_up();
    logic [2:0] want;
    startLocked();
    for (int k = 1; k <= 20; k++) begin
      tick();
      want = {(k < 15), (k >= 15), 1'b0};
      total++;
      if ({sysReset, sysReady, lockLost} !== want) begin
        bad++;
        $display("FAIL power_up k=%0d got=%b want=%b", k, {sysReset, sysReady, lockLost}, want);
      end
      total++;
      if ({sysReset, sysReady, lockLost} !== {mReset, mReady, mLost}) begin
        bad++;
        $display("FAIL power_up_model k=%0d got=%b want=%b", k,
                 {sysReset, sysReady, lockLost}, {mReset, mReady, mLost});
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] want;
    startLocked();
    for (int k = 1; k <= 26; k++) begin
      tick();
      want = {(k < 21), (k >= 21), 1'b0};
      total++;
      if ({sysReset, sysReady, lockLost} !== want) begin
        bad++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, {sysReset, sysReady, lockLost}, want);
      end
      if (k == 5) isLocked = 1'b0;
      if (k == 6) isLocked = 1'b1;
    end
  endtask

  task automatic test_run_loss();
    logic [2:0] want;
    startLocked();
    repeat (20) tick();
    isLocked = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      want = {(k >= 3 && k < 21), (k < 3 || k >= 21), (k == 3)};
      total++;
      if ({sysReset, sysReady, lockLost} !== want) begin
        bad++;
        $display("FAIL run_loss k=%0d got=%b want=%b", k, {sysReset, sysReady, lockLost}, want);
      end
      total++;
      if ({sysReset, sysReady, lockLost} !== {mReset, mReady, mLost}) begin
        bad++;
        $display("FAIL run_loss_model k=%0d got=%b want=%b", k,
                 {sysReset, sysReady, lockLost}, {mReset, mReady, mLost});
      end
      if (k == 6) isLocked = 1'b1;
    end
  endtask

  task automatic test_hold_loss();
    logic [2:0] want;
    startLocked();
    for (int k = 1; k <= 25; k++) begin
      tick();
      want = {1'b1, 1'b0, (k == 13)};
      total++;
      if ({sysReset, sysReady, lockLost} !== want) begin
        bad++;
        $display("FAIL hold_loss k=%0d got=%b want=%b", k, {sysReset, sysReady, lockLost}, want);
      end
      if (k == 10) isLocked = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    startLocked();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({sysReset, sysReady, lockLost} !== 3'b100) begin
      bad++;
      $display("FAIL reset_mid_stab got=%b want=100", {sysReset, sysReady, lockLost});
    end
    reset = 1'b0;
    repeat (20) tick();
    total++;
    if ({sysReset, sysReady} !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_reach_run got=%b want=01", {sysReset, sysReady});
    end
    // reset and lock loss together: reset must win, no pulse
    reset = 1'b1;
    isLocked = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if ({sysReset, sysReady, lockLost} !== 3'b100) begin
        bad++;
        $display("FAIL reset_mid_run k=%0d got=%b want=100", k, {sysReset, sysReady, lockLost});
      end
      if (k == 1) reset = 1'b0;
    end
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    total++;
    if (lossCount !== '0) begin
      bad++;
      $display("FAIL reset_mid_lossCount got=%0d want=0", lossCount);
    end
`endif
  endtask

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  task automatic test_loss_count();
    int expCnt[5] = '{1, 2, 3, 3, 3};
    startLocked();
    for (int i = 0; i < 5; i++) begin
      isLocked = 1'b1;
      repeat (20) tick();
      isLocked = 1'b0;
      repeat (4) tick();
      total++;
      if (lossCount !== LW'(expCnt[i])) begin
        bad++;
        $display("FAIL loss_count i=%0d got=%0d want=%0d", i, lossCount, expCnt[i]);
      end
    end
    reset = 1'b1;
    tick();
    total++;
    if (lossCount !== '0) begin
      bad++;
      $display("FAIL loss_count_reset got=%0d want=0", lossCount);
    end
    reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    int holdLeft = 0;
    startLocked();
    for (int n = 0; n < 4000; n++) begin
      tick();
      total++;
      if ({sysReset, sysReady, lockLost} !== {mReset, mReady, mLost}) begin
        bad++;
        $display("FAIL random n=%0d got=%b want=%b", n,
                 {sysReset, sysReady, lockLost}, {mReset, mReady, mLost});
      end
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      total++;
      if (lossCount !== LW'(mLoss)) begin
        bad++;
        $display("FAIL random_lossCount n=%0d got=%0d want=%0d", n, lossCount, mLoss);
      end
`endif
      if (holdLeft == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          isLocked = 1'b1;
          holdLeft = $urandom_range(1, 40);
        end else begin
          isLocked = 1'b0;
          holdLeft = $urandom_range(1, 6);
        end
      end else begin
        holdLeft--;
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_run_loss();
    test_hold_loss();
    test_reset_mid();
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    test_loss_count();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
